l1_dcache: RTL and testbench

//  L1 data cache: direct-mapped, write-back, write-allocate. Serves the CPU memory-stage port
//  (dcache_* signals driven by the ME stage and its store/load controller).

---
 rtl/l1_dcache.sv | 163 ++++++++++++++++
 tb/tb_l1_dcache.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-back, write-allocate L1 data cache.
//
// The CPU memory stage holds a request until dcache_resp. Hits complete in
// the request cycle. A miss to a dirty victim first writes the victim line
// back, then fills the requested line. The request is still held, so it hits
// in the cycle after the fill.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   dcache_mem_req    CPU request (held until dcache_resp)
//   dcache_we_on_req  1 = store, 0 = load
//   dcache_addr       byte address: [3:0] offset, [3+SET_BITS:4] index, rest tag
//   dcache_wdata      store data, already placed at its line position
//   dcache_byte_en    per-byte store enables within the line
//   dcache_rdata      full line of the indexed set
//   dcache_resp       completion pulse (combinational on an IDLE hit)
//   pmem_addr         line-aligned memory address
//   pmem_read         line fill request, held until pmem_resp
//   pmem_write        line write-back request, held until pmem_resp
//   pmem_wdata        victim line
//   pmem_rdata        fill data, valid with pmem_resp
//   pmem_resp         memory completion pulse
module l1_dcache #(
    parameter int unsigned SET_BITS = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         dcache_mem_req,
    input  logic         dcache_we_on_req,
    input  logic [15:0]  dcache_addr,
    input  logic [127:0] dcache_wdata,
    input  logic [15:0]  dcache_byte_en,
    output logic [127:0] dcache_rdata,
    output logic         dcache_resp,
    output logic [15:0]  pmem_addr,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int unsigned NUM_SETS = 1 << SET_BITS;
    localparam int unsigned TAG_W    = 12 - SET_BITS;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    state_t               state_r;
    logic [NUM_SETS-1:0]  valid_r;
    logic [NUM_SETS-1:0]  dirty_r;
    logic [TAG_W-1:0]     tag_r  [NUM_SETS];
    logic [127:0]         data_r [NUM_SETS];
    logic                 pmem_read_r;
    logic                 pmem_write_r;

    logic [SET_BITS-1:0]  idx_s;
    logic [TAG_W-1:0]     req_tag_s;
    logic                 hit_s;
    logic                 store_hit_s;
    logic                 fill_done_s;
    logic                 addr_offset_unused_s;

    // Replace the enabled bytes of a line with the corresponding store bytes.
    function automatic logic [127:0] merge_bytes(input logic [127:0] old_line,
                                                 input logic [127:0] new_line,
                                                 input logic [15:0]  be);
        logic [127:0] merged;
        for (int b = 0; b < 16; b++) begin
            merged[b*8 +: 8] = be[b] ? new_line[b*8 +: 8] : old_line[b*8 +: 8];
        end
        return merged;
    endfunction

    assign idx_s       = dcache_addr[3+SET_BITS:4];
    assign req_tag_s   = dcache_addr[15:4+SET_BITS];
    assign hit_s       = valid_r[idx_s] && (tag_r[idx_s] == req_tag_s);
    assign store_hit_s = (state_r == ST_IDLE) && dcache_mem_req && dcache_we_on_req && hit_s;
    assign fill_done_s = (state_r == ST_ALLOCATE) && pmem_resp;

    // The byte offset only selects data inside the CPU; the cache works on whole lines.
    assign addr_offset_unused_s = ^dcache_addr[3:0];

    // Controller: state, per-set valid/dirty bits and the memory request strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            valid_r      <= '0;
            dirty_r      <= '0;
            pmem_read_r  <= 1'b0;
            pmem_write_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (dcache_mem_req && hit_s) begin
                        if (dcache_we_on_req) begin
                            dirty_r[idx_s] <= 1'b1;
                        end
                    end else if (dcache_mem_req) begin
                        if (valid_r[idx_s] && dirty_r[idx_s]) begin
                            state_r      <= ST_WRITEBACK;
                            pmem_write_r <= 1'b1;
                        end else begin
                            state_r     <= ST_ALLOCATE;
                            pmem_read_r <= 1'b1;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (pmem_resp) begin
                        dirty_r[idx_s] <= 1'b0;
                        state_r        <= ST_ALLOCATE;
                        pmem_write_r   <= 1'b0;
                        pmem_read_r    <= 1'b1;
                    end
                end
                ST_ALLOCATE: begin
                    if (pmem_resp) begin
                        valid_r[idx_s] <= 1'b1;
                        dirty_r[idx_s] <= 1'b0;
                        state_r        <= ST_IDLE;
                        pmem_read_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    pmem_read_r  <= 1'b0;
                    pmem_write_r <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data storage (deliberately not reset; valid_r qualifies them).
    always_ff @(posedge clk) begin
        if (fill_done_s) begin
            data_r[idx_s] <= pmem_rdata;
            tag_r[idx_s]  <= req_tag_s;
        end else if (store_hit_s) begin
            data_r[idx_s] <= merge_bytes(data_r[idx_s], dcache_wdata, dcache_byte_en);
        end
    end

    // Memory address: the victim line during write-back, otherwise the requested line.
    always_comb begin
        pmem_addr = {dcache_addr[15:4], 4'h0};
        if (state_r == ST_WRITEBACK) begin
            pmem_addr = {tag_r[idx_s], idx_s, 4'h0};
        end else begin
            pmem_addr = {dcache_addr[15:4], 4'h0};
        end
    end

    assign dcache_resp  = (state_r == ST_IDLE) && dcache_mem_req && hit_s;
    assign dcache_rdata = data_r[idx_s];
    assign pmem_wdata   = data_r[idx_s];
    assign pmem_read    = pmem_read_r;
    assign pmem_write   = pmem_write_r;

endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache: a behavioural memory serves fills and
// write-backs; expected line reads and memory transactions are queued when a
// request is driven and compared when the cache produces them.
module tb_l1_dcache;

    localparam int SET_BITS = 3;
    localparam int MEM_LAT  = 2;
    localparam int TIMEOUT  = 200;

    logic         clk;
    logic         rst_n;
    logic         dcache_mem_req;
    logic         dcache_we_on_req;
    logic [15:0]  dcache_addr;
    logic [127:0] dcache_wdata;
    logic [15:0]  dcache_byte_en;
    logic [127:0] dcache_rdata;
    logic         dcache_resp;
    logic [15:0]  pmem_addr;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    l1_dcache #(.SET_BITS(SET_BITS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dcache_mem_req   (dcache_mem_req),
        .dcache_we_on_req (dcache_we_on_req),
        .dcache_addr      (dcache_addr),
        .dcache_wdata     (dcache_wdata),
        .dcache_byte_en   (dcache_byte_en),
        .dcache_rdata     (dcache_rdata),
        .dcache_resp      (dcache_resp),
        .pmem_addr        (pmem_addr),
        .pmem_read        (pmem_read),
        .pmem_write       (pmem_write),
        .pmem_wdata       (pmem_wdata),
        .pmem_rdata       (pmem_rdata),
        .pmem_resp        (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         is_write;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } ev_t;

    int           n_checks = 0;
    int           n_pass   = 0;
    ev_t          exp_ev_q [$];
    logic [127:0] exp_rd_q [$];
    logic [127:0] mem [logic [11:0]];
    logic [127:0] line_mod;
    logic [127:0] sm_line;

    function automatic logic [127:0] line_pat(input logic [11:0] la);
        logic [127:0] p;
        for (int k = 0; k < 8; k++) p[k*16 +: 16] = {la, 4'h0} + 16'(k);
        return p;
    endfunction

    function automatic logic [127:0] mem_read(input logic [11:0] la);
        if (mem.exists(la)) return mem[la];
        return line_pat(la);
    endfunction

    function automatic ev_t mk_ev(input logic w, input logic [15:0] a, input logic [127:0] d);
        ev_t e;
        e.is_write = w;
        e.addr     = a;
        e.wdata    = d;
        return e;
    endfunction

    // Drive one request and act as memory until the cache responds; scoreboard
    // entries are popped and compared as memory transactions and load data appear.
    task automatic access(input logic we, input logic [15:0] addr, input logic [127:0] wdata,
                          input logic [15:0] be, output int lat);
        int   wait_cnt;
        bit   done;
        ev_t  e;
        logic [127:0] exp_line;
        lat = -1; wait_cnt = 0; done = 1'b0;
        dcache_mem_req = 1'b1; dcache_we_on_req = we; dcache_addr = addr;
        dcache_wdata = wdata; dcache_byte_en = be;
        for (int cyc = 0; cyc < TIMEOUT && !done; cyc++) begin
            @(negedge clk);
            pmem_resp = 1'b0;
            n_checks++;
            if (pmem_read && pmem_write)
                $display("FAIL strobe_exclusive: read=%b write=%b, required not both 1", pmem_read, pmem_write);
            else n_pass++;
            if (dcache_resp) begin
                done = 1'b1;
                lat  = cyc;
                if (!we) begin
                    n_checks++;
                    if (exp_rd_q.size() == 0) begin
                        $display("FAIL load_data: unexpected load response addr=%h", addr);
                    end else begin
                        exp_line = exp_rd_q.pop_front();
                        if (dcache_rdata !== exp_line)
                            $display("FAIL load_data addr=%h: got %h, required %h", addr, dcache_rdata, exp_line);
                        else n_pass++;
                    end
                end
            end else if (pmem_read || pmem_write) begin
                wait_cnt++;
                if (wait_cnt == MEM_LAT) begin
                    wait_cnt = 0;
                    n_checks++;
                    if (exp_ev_q.size() == 0) begin
                        $display("FAIL pmem_txn: unexpected write=%b addr=%h", pmem_write, pmem_addr);
                    end else begin
                        e = exp_ev_q.pop_front();
                        if (pmem_write !== e.is_write || pmem_addr !== e.addr ||
                            (e.is_write && pmem_wdata !== e.wdata))
                            $display("FAIL pmem_txn: got write=%b addr=%h data=%h, required write=%b addr=%h data=%h",
                                     pmem_write, pmem_addr, pmem_wdata, e.is_write, e.addr, e.wdata);
                        else n_pass++;
                    end
                    if (pmem_write) mem[pmem_addr[15:4]] = pmem_wdata;
                    else pmem_rdata = mem_read(pmem_addr[15:4]);
                    pmem_resp = 1'b1;
                end
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL access_timeout addr=%h: no resp in %0d cycles, required resp", addr, TIMEOUT);
        end
        @(posedge clk);
        #1;
        dcache_mem_req = 1'b0;
        pmem_resp      = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pmem_resp = 1'b0; pmem_rdata = '0;
        dcache_mem_req = 1'b1; dcache_we_on_req = 1'b0; dcache_addr = 16'h1234;
        dcache_wdata = '0; dcache_byte_en = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (pmem_read !== 1'b0) $display("FAIL reset_pmem_read: got %b, required 0", pmem_read); else n_pass++;
        n_checks++; if (pmem_write !== 1'b0) $display("FAIL reset_pmem_write: got %b, required 0", pmem_write); else n_pass++;
        n_checks++; if (dcache_resp !== 1'b0) $display("FAIL reset_resp: got %b, required 0", dcache_resp); else n_pass++;
        dcache_mem_req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_cold_read();
        int lat;
        exp_ev_q.push_back(mk_ev(1'b0, 16'h1230, 128'h0));
        exp_rd_q.push_back(line_pat(12'h123));
        access(1'b0, 16'h1234, 128'h0, 16'h0000, lat);
        n_checks++; if (lat !== MEM_LAT + 1) $display("FAIL cold_miss_latency: got %0d, required %0d", lat, MEM_LAT + 1); else n_pass++;
        n_checks++; if (exp_ev_q.size() != 0) $display("FAIL cold_miss_txns: %0d missing, required 0", exp_ev_q.size()); else n_pass++;
        exp_rd_q.push_back(line_pat(12'h123));
        access(1'b0, 16'h1234, 128'h0, 16'h0000, lat);
        n_checks++; if (lat !== 0) $display("FAIL reload_hit_latency: got %0d, required 0", lat); else n_pass++;
    endtask

    task automatic test_store_hit();
        int lat;
        logic [127:0] wd;
        wd = {$urandom, $urandom, $urandom, $urandom};
        wd[47:32] = 16'hBEEF;
        line_mod = line_pat(12'h123);
        line_mod[47:32] = 16'hBEEF;
        access(1'b1, 16'h1234, wd, 16'h0030, lat);
        n_checks++; if (lat !== 0) $display("FAIL store_hit_latency: got %0d, required 0", lat); else n_pass++;
        exp_rd_q.push_back(line_mod);
        access(1'b0, 16'h1234, 128'h0, 16'h0000, lat);
        n_checks++; if (lat !== 0) $display("FAIL store_reload_latency: got %0d, required 0", lat); else n_pass++;
    endtask

    task automatic test_dirty_evict();
        int lat;
        exp_ev_q.push_back(mk_ev(1'b1, 16'h1230, line_mod));
        exp_ev_q.push_back(mk_ev(1'b0, 16'h5230, 128'h0));
        exp_rd_q.push_back(line_pat(12'h523));
        access(1'b0, 16'h5230, 128'h0, 16'h0000, lat);
        n_checks++; if (lat !== 2 * MEM_LAT + 1) $display("FAIL dirty_evict_latency: got %0d, required %0d", lat, 2 * MEM_LAT + 1); else n_pass++;
        n_checks++; if (exp_ev_q.size() != 0) $display("FAIL dirty_evict_txns: %0d missing, required 0", exp_ev_q.size()); else n_pass++;
    endtask

    task automatic test_clean_evict();
        int lat;
        // Set 3 holds a clean 0x5230 line; the written-back 0x1230 line must come back intact.
        exp_ev_q.push_back(mk_ev(1'b0, 16'h1230, 128'h0));
        exp_rd_q.push_back(line_mod);
        access(1'b0, 16'h1234, 128'h0, 16'h0000, lat);
        n_checks++; if (lat !== MEM_LAT + 1) $display("FAIL clean_evict_latency: got %0d, required %0d", lat, MEM_LAT + 1); else n_pass++;
        exp_ev_q.push_back(mk_ev(1'b0, 16'h5230, 128'h0));
        exp_rd_q.push_back(line_pat(12'h523));
        access(1'b0, 16'h5238, 128'h0, 16'h0000, lat);
        n_checks++; if (lat !== MEM_LAT + 1) $display("FAIL clean_evict2_latency: got %0d, required %0d", lat, MEM_LAT + 1); else n_pass++;
        n_checks++; if (exp_ev_q.size() != 0) $display("FAIL clean_evict_txns: %0d missing, required 0", exp_ev_q.size()); else n_pass++;
    endtask

    task automatic test_byte_en_zero();
        int lat;
        access(1'b1, 16'h5234, {128{1'b1}}, 16'h0000, lat);
        n_checks++; if (lat !== 0) $display("FAIL be0_store_latency: got %0d, required 0", lat); else n_pass++;
        exp_rd_q.push_back(line_pat(12'h523));
        access(1'b0, 16'h5230, 128'h0, 16'h0000, lat);
        n_checks++; if (lat !== 0) $display("FAIL be0_reload_latency: got %0d, required 0", lat); else n_pass++;
        // The empty store still marks the line dirty, so evicting it writes it back.
        exp_ev_q.push_back(mk_ev(1'b1, 16'h5230, line_pat(12'h523)));
        exp_ev_q.push_back(mk_ev(1'b0, 16'h1230, 128'h0));
        exp_rd_q.push_back(line_mod);
        access(1'b0, 16'h1234, 128'h0, 16'h0000, lat);
        n_checks++; if (lat !== 2 * MEM_LAT + 1) $display("FAIL be0_evict_latency: got %0d, required %0d", lat, 2 * MEM_LAT + 1); else n_pass++;
        n_checks++; if (exp_ev_q.size() != 0) $display("FAIL be0_evict_txns: %0d missing, required 0", exp_ev_q.size()); else n_pass++;
    endtask

    task automatic test_store_miss();
        int lat;
        logic [127:0] wd;
        wd = '0;
        wd[31:0] = 32'hCAFEF00D;
        sm_line = line_pat(12'h234);
        sm_line[31:0] = 32'hCAFEF00D;
        exp_ev_q.push_back(mk_ev(1'b0, 16'h2340, 128'h0));
        access(1'b1, 16'h2345, wd, 16'h000F, lat);
        n_checks++; if (lat !== MEM_LAT + 1) $display("FAIL store_miss_latency: got %0d, required %0d", lat, MEM_LAT + 1); else n_pass++;
        exp_rd_q.push_back(sm_line);
        access(1'b0, 16'h2340, 128'h0, 16'h0000, lat);
        n_checks++; if (lat !== 0) $display("FAIL store_miss_reload_latency: got %0d, required 0", lat); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0]  b2b_addr [3];
        logic [127:0] b2b_line [3];
        logic [127:0] exp_line;
        b2b_addr[0] = 16'h1234; b2b_line[0] = line_mod;
        b2b_addr[1] = 16'h2340; b2b_line[1] = sm_line;
        b2b_addr[2] = 16'h1238; b2b_line[2] = line_mod;
        dcache_mem_req = 1'b1; dcache_we_on_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dcache_addr = b2b_addr[i];
            exp_rd_q.push_back(b2b_line[i]);
            @(negedge clk);
            exp_line = exp_rd_q.pop_front();
            n_checks++;
            if (dcache_resp !== 1'b1 || dcache_rdata !== exp_line)
                $display("FAIL back_to_back[%0d]: resp=%b data=%h, required resp=1 data=%h", i, dcache_resp, dcache_rdata, exp_line);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        dcache_mem_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        bit found;
        found = 1'b0;
        dcache_mem_req = 1'b1; dcache_we_on_req = 1'b0; dcache_addr = 16'h6234;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (pmem_read) found = 1'b1;
        end
        n_checks++; if (!found) $display("FAIL reset_mid_fill_start: pmem_read=%b, required 1", pmem_read); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (pmem_read !== 1'b0) $display("FAIL reset_mid_pmem_read: got %b, required 0", pmem_read); else n_pass++;
        n_checks++; if (pmem_write !== 1'b0) $display("FAIL reset_mid_pmem_write: got %b, required 0", pmem_write); else n_pass++;
        dcache_mem_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_ev_q.push_back(mk_ev(1'b0, 16'h1230, 128'h0));
        exp_rd_q.push_back(line_mod);
        access(1'b0, 16'h1234, 128'h0, 16'h0000, lat);
        n_checks++; if (lat !== MEM_LAT + 1) $display("FAIL reset_mid_remiss_latency: got %0d, required %0d", lat, MEM_LAT + 1); else n_pass++;
    endtask

    task automatic test_last_set();
        int lat;
        logic [15:0] a;
        // A stray memory response while idle must not change anything.
        @(negedge clk); pmem_resp = 1'b1;
        @(negedge clk); pmem_resp = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            a = (i % 2 == 1) ? 16'h01F2 : 16'h00F2;
            exp_ev_q.push_back(mk_ev(1'b0, {a[15:4], 4'h0}, 128'h0));
            exp_rd_q.push_back(line_pat(a[15:4]));
            access(1'b0, a, 128'h0, 16'h0000, lat);
            n_checks++; if (lat !== MEM_LAT + 1) $display("FAIL last_set[%0d]_latency: got %0d, required %0d", i, lat, MEM_LAT + 1); else n_pass++;
        end
        n_checks++; if (exp_ev_q.size() != 0) $display("FAIL last_set_txns: %0d missing, required 0", exp_ev_q.size()); else n_pass++;
        exp_rd_q.push_back(line_mod);
        access(1'b0, 16'h1234, 128'h0, 16'h0000, lat);
        n_checks++; if (lat !== 0) $display("FAIL other_set_undisturbed: latency %0d, required 0", lat); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_store_hit();
        test_dirty_evict();
        test_clean_evict();
        test_byte_en_zero();
        test_store_miss();
        test_back_to_back();
        test_reset_mid();
        test_last_set();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
